// File: rtl/zx_kbd_pkg.sv
// Shared definitions for the PS/2 to ZX Spectrum keyboard matrix bridge.
// Defines the decoder state enum, the matrix position struct, the prefix and
// BAT scan-code constants, and the positions of the keys used by the
// optional extended keys (build macro EXTENDED_KEYS_EN).
package zx_kbd_pkg;

    // Decoder states: plain, after E0, after F0, after E0 F0.
    typedef enum logic [1:0] {
        KBD_IDLE = 2'd0,
        KBD_E0   = 2'd1,
        KBD_F0   = 2'd2,
        KBD_E0F0 = 2'd3
    } kbd_state_t;

    // One key position in the 8 x 5 ZX matrix (row = A[8+row], col = data bit).
    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } zx_pos_t;

    localparam int ZX_ROWS  = 8;
    localparam int ZX_COLS  = 5;
    localparam int EXT_KEYS = 5;

    // Scan-code constants handled by the decoder itself.
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;

    // Slots in ext_held; each slot means CAPS SHIFT plus one digit key.
    localparam logic [2:0] EXT_LEFT  = 3'd0;   // CAPS+5
    localparam logic [2:0] EXT_DOWN  = 3'd1;   // CAPS+6
    localparam logic [2:0] EXT_UP    = 3'd2;   // CAPS+7
    localparam logic [2:0] EXT_RIGHT = 3'd3;   // CAPS+8
    localparam logic [2:0] EXT_BKSP  = 3'd4;   // CAPS+0

    // Build a matrix position from row and column numbers.
    function automatic zx_pos_t zx_pos(input logic [2:0] row, input logic [2:0] col);
        zx_pos_t p;
        p.row = row;
        p.col = col;
        return p;
    endfunction

    // Matrix positions of the keys the extended slots fold into.
    localparam zx_pos_t POS_CAPS = '{row: 3'd0, col: 3'd0};
    localparam zx_pos_t POS_D5   = '{row: 3'd3, col: 3'd4};
    localparam zx_pos_t POS_D6   = '{row: 3'd4, col: 3'd4};
    localparam zx_pos_t POS_D7   = '{row: 3'd4, col: 3'd3};
    localparam zx_pos_t POS_D8   = '{row: 3'd4, col: 3'd2};
    localparam zx_pos_t POS_D0   = '{row: 3'd4, col: 3'd0};

endpackage

// File: rtl/ps2_zx_keymap.sv
// Combinational PS/2 set-2 scan code to ZX matrix position lookup.
// 'extended' is set when the byte followed an E0 prefix. With
// EXTENDED_KEYS_EN defined, an extra port pair reports arrow and Backspace
// keys as ext_held slot numbers; those keys never map to a matrix bit here.
module ps2_zx_keymap
    import zx_kbd_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       extended,
    output logic       valid,
    output zx_pos_t    pos
`ifdef EXTENDED_KEYS_EN
    ,
    output logic       ext_valid,
    output logic [2:0] ext_idx
`endif
);

    // Plain matrix keys: letters, digits, Enter, Space, Shifts, Ctrls.
    always_comb begin
        valid = 1'b1;
        pos   = zx_pos(3'd0, 3'd0);
        if (extended) begin
            unique case (scan_code)
                8'h14:   pos = zx_pos(3'd7, 3'd1);   // right Ctrl -> SYMBOL SHIFT
                default: valid = 1'b0;
            endcase
        end else begin
            unique case (scan_code)
                // row 0: CAPS Z X C V
                8'h12:   pos = zx_pos(3'd0, 3'd0);
                8'h59:   pos = zx_pos(3'd0, 3'd0);
                8'h1A:   pos = zx_pos(3'd0, 3'd1);
                8'h22:   pos = zx_pos(3'd0, 3'd2);
                8'h21:   pos = zx_pos(3'd0, 3'd3);
                8'h2A:   pos = zx_pos(3'd0, 3'd4);
                // row 1: A S D F G
                8'h1C:   pos = zx_pos(3'd1, 3'd0);
                8'h1B:   pos = zx_pos(3'd1, 3'd1);
                8'h23:   pos = zx_pos(3'd1, 3'd2);
                8'h2B:   pos = zx_pos(3'd1, 3'd3);
                8'h34:   pos = zx_pos(3'd1, 3'd4);
                // row 2: Q W E R T
                8'h15:   pos = zx_pos(3'd2, 3'd0);
                8'h1D:   pos = zx_pos(3'd2, 3'd1);
                8'h24:   pos = zx_pos(3'd2, 3'd2);
                8'h2D:   pos = zx_pos(3'd2, 3'd3);
                8'h2C:   pos = zx_pos(3'd2, 3'd4);
                // row 3: 1 2 3 4 5
                8'h16:   pos = zx_pos(3'd3, 3'd0);
                8'h1E:   pos = zx_pos(3'd3, 3'd1);
                8'h26:   pos = zx_pos(3'd3, 3'd2);
                8'h25:   pos = zx_pos(3'd3, 3'd3);
                8'h2E:   pos = zx_pos(3'd3, 3'd4);
                // row 4: 0 9 8 7 6
                8'h45:   pos = zx_pos(3'd4, 3'd0);
                8'h46:   pos = zx_pos(3'd4, 3'd1);
                8'h3E:   pos = zx_pos(3'd4, 3'd2);
                8'h3D:   pos = zx_pos(3'd4, 3'd3);
                8'h36:   pos = zx_pos(3'd4, 3'd4);
                // row 5: P O I U Y
                8'h4D:   pos = zx_pos(3'd5, 3'd0);
                8'h44:   pos = zx_pos(3'd5, 3'd1);
                8'h43:   pos = zx_pos(3'd5, 3'd2);
                8'h3C:   pos = zx_pos(3'd5, 3'd3);
                8'h35:   pos = zx_pos(3'd5, 3'd4);
                // row 6: ENTER L K J H
                8'h5A:   pos = zx_pos(3'd6, 3'd0);
                8'h4B:   pos = zx_pos(3'd6, 3'd1);
                8'h42:   pos = zx_pos(3'd6, 3'd2);
                8'h3B:   pos = zx_pos(3'd6, 3'd3);
                8'h33:   pos = zx_pos(3'd6, 3'd4);
                // row 7: SPACE SYM M N B
                8'h29:   pos = zx_pos(3'd7, 3'd0);
                8'h14:   pos = zx_pos(3'd7, 3'd1);
                8'h3A:   pos = zx_pos(3'd7, 3'd2);
                8'h31:   pos = zx_pos(3'd7, 3'd3);
                8'h32:   pos = zx_pos(3'd7, 3'd4);
                default: valid = 1'b0;
            endcase
        end
    end

`ifdef EXTENDED_KEYS_EN
    // Arrow keys (E0-prefixed) and Backspace (plain) map to ext_held slots.
    always_comb begin
        ext_valid = 1'b1;
        ext_idx   = EXT_LEFT;
        unique case ({extended, scan_code})
            9'h16B:  ext_idx = EXT_LEFT;
            9'h172:  ext_idx = EXT_DOWN;
            9'h175:  ext_idx = EXT_UP;
            9'h174:  ext_idx = EXT_RIGHT;
            9'h066:  ext_idx = EXT_BKSP;
            default: ext_valid = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/zx_keymatrix.sv
// PS/2 scan-code decoder driving a ZX Spectrum 8 x 5 keyboard matrix.
// Prefix decoding (E0 / F0 / E0 F0) sets or clears registered "pressed" bits;
// the CPU reads the active-low columns of the half-rows selected by A[15:8]
// combinationally. Build macro EXTENDED_KEYS_EN adds arrow and Backspace keys
// that assert CAPS SHIFT plus a digit through the ext_held register.
module zx_keymatrix
    import zx_kbd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_code_ready,
    input  logic        scan_code_error,
    input  logic [15:0] A,
    output logic [4:0]  key_row
);

    kbd_state_t                      state_reg, state_next;
    logic [ZX_ROWS-1:0][ZX_COLS-1:0] pressed_reg, pressed_next;
    logic [EXT_KEYS-1:0]             ext_held;
    logic [ZX_ROWS-1:0][ZX_COLS-1:0] eff_matrix;
    logic [ZX_ROWS-1:0][ZX_COLS-1:0] row_sel_bits;

    logic    map_extended;
    logic    map_valid;
    zx_pos_t map_pos;
    logic    is_make;
    logic    key_event;
    logic    bat_clear;

    // The low address byte does not take part in half-row selection.
    logic unused_addr_lo;
    assign unused_addr_lo = ^A[7:0];

    // The byte is looked up in the context of any prefix already received.
    assign map_extended = (state_reg == KBD_E0) || (state_reg == KBD_E0F0);
    assign is_make      = (state_reg == KBD_IDLE) || (state_reg == KBD_E0);

`ifdef EXTENDED_KEYS_EN
    logic                ext_valid;
    logic [2:0]          ext_idx;
    logic [EXT_KEYS-1:0] ext_held_reg, ext_held_next;

    ps2_zx_keymap u_keymap (
        .scan_code (scan_code),
        .extended  (map_extended),
        .valid     (map_valid),
        .pos       (map_pos),
        .ext_valid (ext_valid),
        .ext_idx   (ext_idx)
    );

    // Extended keys follow the same make/break events as the matrix keys.
    always_comb begin
        ext_held_next = ext_held_reg;
        if (bat_clear) begin
            ext_held_next = '0;
        end else if (key_event && ext_valid) begin
            ext_held_next[ext_idx] = is_make;
        end
    end

    // Extended key state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_held_reg <= '0;
        end else begin
            ext_held_reg <= ext_held_next;
        end
    end

    assign ext_held = ext_held_reg;
`else
    ps2_zx_keymap u_keymap (
        .scan_code (scan_code),
        .extended  (map_extended),
        .valid     (map_valid),
        .pos       (map_pos)
    );

    assign ext_held = '0;
`endif

    // Prefix decoding and matrix update; an error strobe discards the byte.
    always_comb begin
        state_next   = state_reg;
        pressed_next = pressed_reg;
        key_event    = 1'b0;
        bat_clear    = 1'b0;
        if (scan_code_error) begin
            state_next = KBD_IDLE;
        end else if (scan_code_ready) begin
            state_next = KBD_IDLE;
            unique case (state_reg)
                KBD_IDLE: begin
                    if (scan_code == SC_E0) begin
                        state_next = KBD_E0;
                    end else if (scan_code == SC_F0) begin
                        state_next = KBD_F0;
                    end else if (scan_code == SC_AA) begin
                        bat_clear = 1'b1;
                    end else begin
                        key_event = 1'b1;
                    end
                end
                KBD_E0: begin
                    if (scan_code == SC_F0) begin
                        state_next = KBD_E0F0;
                    end else begin
                        key_event = 1'b1;
                    end
                end
                default: key_event = 1'b1;
            endcase
            if (bat_clear) begin
                pressed_next = '0;
            end else if (key_event && map_valid) begin
                pressed_next[map_pos.row][map_pos.col] = is_make;
            end
        end
    end

    // Decoder state and matrix registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= KBD_IDLE;
            pressed_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pressed_reg <= pressed_next;
        end
    end

    // Fold held extended keys into CAPS SHIFT and their digit keys.
    always_comb begin
        eff_matrix = pressed_reg;
        eff_matrix[POS_CAPS.row][POS_CAPS.col] = pressed_reg[POS_CAPS.row][POS_CAPS.col] | (|ext_held);
        eff_matrix[POS_D5.row][POS_D5.col] = pressed_reg[POS_D5.row][POS_D5.col] | ext_held[EXT_LEFT];
        eff_matrix[POS_D6.row][POS_D6.col] = pressed_reg[POS_D6.row][POS_D6.col] | ext_held[EXT_DOWN];
        eff_matrix[POS_D7.row][POS_D7.col] = pressed_reg[POS_D7.row][POS_D7.col] | ext_held[EXT_UP];
        eff_matrix[POS_D8.row][POS_D8.col] = pressed_reg[POS_D8.row][POS_D8.col] | ext_held[EXT_RIGHT];
        eff_matrix[POS_D0.row][POS_D0.col] = pressed_reg[POS_D0.row][POS_D0.col] | ext_held[EXT_BKSP];
    end

    // A half-row contributes its keys only when its address line is low.
    generate
        for (genvar gi = 0; gi < ZX_ROWS; gi++) begin : g_row_sel
            assign row_sel_bits[gi] = A[8+gi] ? '0 : eff_matrix[gi];
        end
    endgenerate

    // Active-low column read-back: any pressed key in a selected row pulls low.
    always_comb begin
        logic [ZX_COLS-1:0] any_pressed;
        any_pressed = '0;
        for (int r = 0; r < ZX_ROWS; r++) begin
            any_pressed = any_pressed | row_sel_bits[r];
        end
        key_row = ~any_pressed;
    end

endmodule
